// File: rtl/present_pkg.sv
// PRESENT-80 shared definitions: S-box, round count,
// controller states and key-schedule helpers.
package present_pkg;

  localparam int ROUNDS = 31;

  // nibble i of the table is S(i)
  localparam logic [63:0] SBOX_TBL = 64'h21748FE3DA09B65C;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINAL,
    DONE
  } ctrl_state_e;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    return SBOX_TBL[{x, 2'b00} +: 4];
  endfunction

  function automatic logic [63:0] round_key(input logic [79:0] key80);
    return key80[79:16];
  endfunction

  function automatic logic [79:0] key_update(
    input logic [79:0] key80,
    input logic [4:0]  rc5
  );
    logic [79:0] k;
    k = {key80[18:0], key80[79:19]};
    k[79:76] = sbox(k[79:76]);
    k[19:15] = k[19:15] ^ rc5;
    return k;
  endfunction

endpackage

// File: rtl/present_key_sched.sv
// 80-bit PRESENT key register with on-the-fly schedule.
// Load captures the user key; step advances one round.
module present_key_sched
  import present_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic        step_i,
  input  logic [79:0] key_i,
  input  logic [4:0]  rc_i,
  output logic [63:0] rk_o
);

  logic [79:0] key_q;

  // key register: load wins over step
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      key_q <= '0;
    end else if (load_i) begin
      key_q <= key_i;
    end else if (step_i) begin
      key_q <= key_update(key_q, rc_i);
    end
  end

  assign rk_o = round_key(key_q);

endmodule

// File: rtl/sub_per.sv
// PRESENT round datapath: S-box layer then bit permutation.
// Bit i moves to 16*i mod 63; bit 63 stays put.
module sub_per
  import present_pkg::*;
(
  input  logic [63:0] data_i,
  output logic [63:0] data_o
);

  logic [63:0] s;

  // substitute every nibble, then scatter bits
  always_comb begin
    s = '0;
    data_o = '0;
    for (int i = 0; i < 16; i++) begin
      s[4*i +: 4] = sbox(data_i[4*i +: 4]);
    end
    for (int i = 0; i < 64; i++) begin
      data_o[(i == 63) ? 63 : ((i * 16) % 63)] = s[i];
    end
  end

endmodule

// File: rtl/present_enc_ctrl.sv
// Iterative PRESENT-80 encryption controller.
// One sub_per round per clock, final whitening, then hold.
module present_enc_ctrl #(
  parameter int ROUNDS = present_pkg::ROUNDS
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [63:0] data_i,
  input  logic [79:0] key_i,
  output logic        ready_o,
  output logic [63:0] data_o,
  output logic        valid_o,
  input  logic        ack_i,
  output logic [4:0]  round_o
);

  import present_pkg::*;

  localparam logic [4:0] LAST = 5'(ROUNDS);

  ctrl_state_e state_q, state_d;

  logic [63:0] st_q;
  logic [63:0] out_q;
  logic [4:0]  round_q;
  logic [63:0] rk;
  logic [63:0] sp_out;
  logic        load;
  logic        step;

  present_key_sched u_ks (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (load),
    .step_i (step),
    .key_i  (key_i),
    .rc_i   (round_q),
    .rk_o   (rk)
  );

  sub_per u_sp (
    .data_i (st_q ^ rk),
    .data_o (sp_out)
  );

  // state register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next state and key-schedule controls
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (round_q == LAST) begin
          state_d = FINAL;
        end
      end
      FINAL: begin
        state_d = DONE;
      end
      DONE: begin
        if (ack_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // cipher state, output and round counter
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      st_q    <= '0;
      out_q   <= '0;
      round_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            st_q    <= data_i;
            round_q <= 5'd1;
          end
        end
        RUN: begin
          st_q <= sp_out;
          if (round_q != LAST) begin
            round_q <= round_q + 5'd1;
          end
        end
        FINAL: begin
          out_q <= st_q ^ rk;
        end
        DONE: begin
          if (ack_i) begin
            round_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign ready_o = (state_q == IDLE);
  assign valid_o = (state_q == DONE);
  assign data_o  = out_q;
  assign round_o = round_q;

endmodule

// File: tb/tb_present_enc_ctrl.sv
// Directed bench for present_enc_ctrl using the
// published PRESENT-80 test vectors.
module tb_present_enc_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [63:0] din;
  logic [79:0] key;
  logic        ready;
  logic [63:0] dout;
  logic        valid;
  logic        ack;
  logic [4:0]  round;

  int tests;
  int fails;

  typedef struct {
    logic [63:0] pt;
    logic [79:0] key;
    logic [63:0] ct;
  } vec_t;

  vec_t vecs[4];

  present_enc_ctrl dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .start_i (start),
    .data_i  (din),
    .key_i   (key),
    .ready_o (ready),
    .data_o  (dout),
    .valid_o (valid),
    .ack_i   (ack),
    .round_o (round)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(
    input string       name,
    input logic [79:0] act,
    input logic [79:0] exp
  );
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // start one block; return result and cycles to valid
  task automatic encrypt(
    input  logic [63:0] pt,
    input  logic [79:0] k,
    input  bit          chk_round,
    input  bit          poke_ack,
    output logic [63:0] ct,
    output int          lat
  );
    int exp_r;
    start = 1'b1;
    din   = pt;
    key   = k;
    step();
    start = 1'b0;
    din   = ~pt;
    key   = ~k;
    lat   = 0;
    while (!valid && lat < 40) begin
      if (chk_round) begin
        exp_r = (lat + 1 > 31) ? 31 : lat + 1;
        chk($sformatf("round_seq[%0d]", lat), 80'(round), 80'(exp_r));
      end
      ack = poke_ack && (lat >= 4) && (lat <= 6);
      step();
      lat++;
    end
    ack = 1'b0;
    if (!valid) begin
      chk("valid_timeout", 80'(valid), 80'd1);
    end
    ct = dout;
  endtask

  task automatic do_ack();
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("ack_valid", 80'(valid), 80'd0);
    chk("ack_ready", 80'(ready), 80'd1);
    chk("ack_round", 80'(round), 80'd0);
  endtask

  logic [63:0] ct;
  logic [63:0] held;
  int          lat;
  int          n;

  initial begin
    vecs[0] = '{64'h0, 80'h0, 64'h5579C1387B228445};
    vecs[1] = '{64'h0, {80{1'b1}}, 64'hE72C46C0F5945049};
    vecs[2] = '{{64{1'b1}}, 80'h0, 64'hA112FFC72F68417B};
    vecs[3] = '{{64{1'b1}}, {80{1'b1}}, 64'h3333DCD3213210D2};

    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    start = 1'b0;
    ack   = 1'b0;
    din   = '0;
    key   = '0;
    @(negedge clk);
    step();
    rst_n = 1'b1;
    chk("rst_ready", 80'(ready), 80'd1);
    chk("rst_valid", 80'(valid), 80'd0);
    chk("rst_data", 80'(dout), 80'd0);
    chk("rst_round", 80'(round), 80'd0);

    // table of known-answer vectors
    for (int i = 0; i < 4; i++) begin
      encrypt(vecs[i].pt, vecs[i].key, i == 0, 1'b0, ct, lat);
      chk($sformatf("kat%0d_ct", i), 80'(ct), 80'(vecs[i].ct));
      chk($sformatf("kat%0d_lat", i), 80'(lat), 80'd32);
      if (i == 0) begin
        chk("done_round", 80'(round), 80'd31);
      end
      do_ack();
    end

    // back-pressure: hold result for 20 cycles
    encrypt(64'h0, 80'h0, 1'b0, 1'b0, ct, lat);
    held = dout;
    chk("bp_ct", 80'(held), 80'h5579C1387B228445);
    for (int i = 0; i < 20; i++) begin
      step();
      chk($sformatf("bp_data[%0d]", i), 80'(dout), 80'(held));
      chk($sformatf("bp_valid[%0d]", i), 80'(valid), 80'd1);
      chk($sformatf("bp_ready[%0d]", i), 80'(ready), 80'd0);
    end
    do_ack();

    // ack pulses during RUN change nothing
    encrypt({64{1'b1}}, 80'h0, 1'b0, 1'b1, ct, lat);
    chk("runack_ct", 80'(ct), 80'hA112FFC72F68417B);
    chk("runack_lat", 80'(lat), 80'd32);
    do_ack();

    // start held high: only first sample, then re-accept
    start = 1'b1;
    din   = 64'h0;
    key   = 80'h0;
    step();
    din = 64'h0123456789ABCDEF;
    n = 0;
    while (!valid && n < 40) begin
      step();
      n++;
    end
    chk("hold_lat", 80'(n), 80'd32);
    chk("hold_ct1", 80'(dout), 80'h5579C1387B228445);
    chk("hold_ready", 80'(ready), 80'd0);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("hold_idle", 80'(ready), 80'd1);
    din = {64{1'b1}};
    step();
    start = 1'b0;
    din   = 64'h0;
    n = 0;
    while (!valid && n < 40) begin
      step();
      n++;
    end
    chk("hold_lat2", 80'(n), 80'd32);
    chk("hold_ct2", 80'(dout), 80'hA112FFC72F68417B);
    do_ack();

    // reset at round 15 aborts
    start = 1'b1;
    din   = 64'h0;
    key   = {80{1'b1}};
    step();
    start = 1'b0;
    n = 0;
    while (round != 5'd15 && n < 40) begin
      step();
      n++;
    end
    chk("mid_round", 80'(round), 80'd15);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_ready", 80'(ready), 80'd1);
    chk("mid_valid", 80'(valid), 80'd0);
    chk("mid_round0", 80'(round), 80'd0);
    chk("mid_data", 80'(dout), 80'd0);
    encrypt(64'h0, 80'h0, 1'b0, 1'b0, ct, lat);
    chk("post_rst_ct", 80'(ct), 80'h5579C1387B228445);
    chk("post_rst_lat", 80'(lat), 80'd32);
    do_ack();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
